// File: rtl/cache_pkg.sv
// cache_pkg: shared state type and default widths for the cache miss controller
package cache_pkg;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 128;
  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP} miss_state_t;
endpackage

// File: rtl/cache_miss_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
// Ports: clk, reset (async, active-low), inc (count enable), count (current value)
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (inc && !(&count)) count <= count + WIDTH'(1);
endmodule

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: single-outstanding cache lookup / memory refill controller
// Ports: req_* (requester handshake), resp_* (one-cycle completion),
//        cache_* (lookup and fill port), mem_* (backing memory request/response),
//        hit_cnt/miss_cnt (saturating read statistics); reset is async active-low.
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  cache_read_en,
  output logic                  cache_write_en,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_write_data,
  input  logic [DATA_WIDTH-1:0] cache_read_data,
  input  logic                  cache_hit,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);
  miss_state_t state, state_nx;
  logic wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  // data_q holds the write data, then is overwritten by the hit line or the
  // refilled line, so it always carries what FILL must write into the cache
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      resp_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        wr_q   <= req_write;
        addr_q <= req_addr;
        data_q <= req_wdata;
      end
      if (state == CHECK && cache_hit) begin
        data_q    <= cache_read_data;
        resp_data <= cache_read_data;
      end
      if (state == MEM_WAIT && mem_resp_valid) data_q <= mem_resp_data;
      if (state == FILL) resp_data <= wr_q ? '0 : data_q;
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (req_valid) state_nx = req_write ? MEM_REQ : LOOKUP;
      LOOKUP:   state_nx = CHECK;
      CHECK:    state_nx = cache_hit ? RESP : MEM_REQ;
      MEM_REQ:  if (mem_req_ready) state_nx = wr_q ? FILL : MEM_WAIT;
      MEM_WAIT: if (mem_resp_valid) state_nx = FILL;
      FILL:     state_nx = RESP;
      RESP:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  assign req_ready        = state == IDLE;
  assign resp_valid       = state == RESP;
  assign cache_read_en    = state == LOOKUP;
  assign cache_write_en   = state == FILL;
  assign cache_addr       = addr_q;
  assign cache_write_data = data_q;
  assign mem_req_valid    = state == MEM_REQ;
  assign mem_req_write    = mem_req_valid && wr_q;
  assign mem_req_addr     = addr_q;
  assign mem_req_wdata    = data_q;
  // only reads reach CHECK, so writes never touch the statistics
  sat_counter #(.WIDTH(32)) u_hit (
    .clk   (clk),
    .reset (reset),
    .inc   (state == CHECK && cache_hit),
    .count (hit_cnt)
  );
  sat_counter #(.WIDTH(32)) u_miss (
    .clk   (clk),
    .reset (reset),
    .inc   (state == CHECK && !cache_hit),
    .count (miss_cnt)
  );
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: vector table plus scoreboard check of cache_miss_ctrl
module tb_cache_miss_ctrl;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_ready, req_write = 0;
  logic [31:0] req_addr = 0;
  logic [127:0] req_wdata = 0;
  logic resp_valid;
  logic [127:0] resp_data;
  logic cache_read_en, cache_write_en;
  logic [31:0] cache_addr;
  logic [127:0] cache_write_data, cache_read_data = 0;
  logic cache_hit = 0;
  logic mem_req_valid, mem_req_ready = 0, mem_req_write;
  logic [31:0] mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic mem_resp_valid = 0;
  logic [127:0] mem_resp_data = 0;
  logic [31:0] hit_cnt, miss_cnt;

  cache_miss_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .cache_read_en(cache_read_en), .cache_write_en(cache_write_en),
    .cache_addr(cache_addr), .cache_write_data(cache_write_data),
    .cache_read_data(cache_read_data), .cache_hit(cache_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] data;
    logic         hit;
    logic [31:0]  hc;
    logic [31:0]  mc;
    int           rdy;
    int           rsp;
  } vec_t;
  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] data;
    logic         hit;
    logic [31:0]  hc;
    logic [31:0]  mc;
    int           acc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_err = 0, n_resp = 0, n_cw = 0, cyc = 0;
  int rdy_dly = 0, rsp_dly = 0, rwait = 0, rcnt = 0;
  bit pend = 0, hold = 0;
  logic [31:0] pa;
  logic [127:0] m_arr[logic [31:0]];
  logic [127:0] c_arr[logic [31:0]];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // response scoreboard
  always @(negedge clk) begin
    if (resp_valid) begin
      n_resp++;
      if (q.size() == 0) chk("unexpected_resp", resp_valid, 1'b0);
      else begin
        e = q.pop_front();
        chk("resp_data", resp_data, e.wr ? 128'h0 : e.data);
        chk("hit_cnt", hit_cnt, e.hc);
        chk("miss_cnt", miss_cnt, e.mc);
        if (e.hit) chk("hit_latency", 128'(cyc - e.acc), 128'd3);
      end
    end
  end

  // cache model: lookup result presented the cycle after cache_read_en and held through CHECK
  always @(negedge clk) begin
    if (cache_read_en || cache_write_en) chk("rd_wr_exclusive", cache_read_en && cache_write_en, 1'b0);
    if (cache_read_en) begin
      if (q.size() != 0) chk("lookup_addr", cache_addr, q[0].addr);
      cache_hit = c_arr.exists(cache_addr);
      cache_read_data = cache_hit ? c_arr[cache_addr] : {4{$urandom}};
      hold = 1;
    end else if (hold) hold = 0;
    else cache_hit = 0;
    if (cache_write_en) begin
      n_cw++;
      if (q.size() != 0) begin
        chk("fill_addr", cache_addr, q[0].addr);
        chk("fill_data", cache_write_data, q[0].data);
        chk("fill_on_hit", q[0].hit, 1'b0);
      end
      c_arr[cache_addr] = cache_write_data;
    end
  end

  // memory model with programmable accept and response delays
  always @(negedge clk) begin
    mem_req_ready = 0;
    mem_resp_valid = 0;
    if (mem_req_valid && !pend) begin
      if (q.size() != 0) begin
        chk("mem_addr", mem_req_addr, q[0].addr);
        chk("mem_write", mem_req_write, q[0].wr);
        if (q[0].wr) chk("mem_wdata", mem_req_wdata, q[0].data);
        chk("mem_on_hit", q[0].hit, 1'b0);
      end
      if (rwait >= rdy_dly) begin
        mem_req_ready = 1;
        rwait = 0;
        if (mem_req_write) m_arr[mem_req_addr] = mem_req_wdata;
        else begin
          pend = 1;
          pa = mem_req_addr;
          rcnt = 0;
        end
      end else rwait++;
    end else if (pend) begin
      if (rcnt >= rsp_dly) begin
        mem_resp_valid = 1;
        mem_resp_data = m_arr.exists(pa) ? m_arr[pa] : {4{pa}};
        pend = 0;
      end else rcnt++;
    end
  end

  task automatic issue(input vec_t v, output int waited);
    waited = 0;
    @(negedge clk);
    req_valid = 1;
    req_write = v.wr;
    req_addr = v.addr;
    req_wdata = v.wr ? v.data : 128'h0;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("accept_timeout", req_ready, 1'b1);
      req_valid = 0;
    end else begin
      rdy_dly = v.rdy;
      rsp_dly = v.rsp;
      q.push_back('{v.wr, v.addr, v.data, v.hit, v.hc, v.mc, cyc});
      @(posedge clk);
      #1 req_valid = 0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("resp_timeout", 1'b0, 1'b1);
    q.delete();
  endtask

  task automatic chk_rst();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 128'h0);
    chk("rst_cache_rd", cache_read_en, 1'b0);
    chk("rst_cache_wr", cache_write_en, 1'b0);
    chk("rst_cache_addr", cache_addr, 32'h0);
    chk("rst_cache_wdata", cache_write_data, 128'h0);
    chk("rst_mem_valid", mem_req_valid, 1'b0);
    chk("rst_mem_write", mem_req_write, 1'b0);
    chk("rst_mem_addr", mem_req_addr, 32'h0);
    chk("rst_mem_wdata", mem_req_wdata, 128'h0);
    chk("rst_hit_cnt", hit_cnt, 32'h0);
    chk("rst_miss_cnt", miss_cnt, 32'h0);
  endtask

  vec_t tbl[9];
  vec_t v;
  int w, r0, cw0, n;

  initial begin
    tbl[0] = '{1'b1, 32'h40,  {16{8'hA5}},   1'b0, 32'd0, 32'd0, 0, 0};
    tbl[1] = '{1'b0, 32'h40,  {16{8'hA5}},   1'b1, 32'd1, 32'd0, 0, 0};
    tbl[2] = '{1'b0, 32'h80,  128'h1234,     1'b0, 32'd1, 32'd1, 2, 3};
    tbl[3] = '{1'b0, 32'h80,  128'h1234,     1'b1, 32'd2, 32'd1, 0, 0};
    tbl[4] = '{1'b1, 32'hC0,  128'hDEAD,     1'b0, 32'd2, 32'd1, 1, 0};
    tbl[5] = '{1'b0, 32'hC0,  128'hDEAD,     1'b1, 32'd3, 32'd1, 0, 0};
    tbl[6] = '{1'b0, 32'h100, {4{32'h100}},  1'b0, 32'd3, 32'd2, 0, 1};
    tbl[7] = '{1'b1, 32'h80,  128'hBEEF,     1'b0, 32'd3, 32'd2, 0, 0};
    tbl[8] = '{1'b0, 32'h80,  128'hBEEF,     1'b1, 32'd4, 32'd2, 0, 0};
    m_arr[32'h80] = 128'h1234;
    #2 reset = 0;
    #1 chk_rst();
    repeat (2) @(negedge clk);
    #2 reset = 1;
    for (int i = 0; i < 9; i++) begin
      issue(tbl[i], w);
      wait_done();
    end
    // requester keeps a second request pending while a miss is serviced
    v = '{1'b0, 32'h200, {4{32'h200}}, 1'b0, 32'd4, 32'd3, 1, 2};
    issue(v, w);
    r0 = n_resp;
    v = '{1'b0, 32'h40, {16{8'hA5}}, 1'b1, 32'd5, 32'd3, 0, 0};
    issue(v, w);
    chk("bp_first_resp_before_accept", 128'(n_resp - r0), 128'd1);
    chk("bp_ready_low_during_miss", w >= 6, 1'b1);
    wait_done();
    // reset while the refill is outstanding; the memory answers after release
    v = '{1'b0, 32'h300, {4{32'h300}}, 1'b0, 32'd5, 32'd4, 0, 10};
    issue(v, w);
    n = 0;
    while (!pend && n < 100) begin
      @(negedge clk);
      #1 n++;
    end
    chk("mem_handshake_seen", pend, 1'b1);
    @(negedge clk);
    #2 reset = 0;
    #1 chk_rst();
    q.delete();
    cw0 = n_cw;
    r0 = n_resp;
    repeat (2) @(negedge clk);
    #2 reset = 1;
    repeat (15) @(negedge clk);
    #1;
    chk("late_resp_delivered", pend, 1'b0);
    chk("rst_no_fill", 128'(n_cw), 128'(cw0));
    chk("rst_no_resp", 128'(n_resp), 128'(r0));
    chk("rst_idle", req_ready, 1'b1);
    chk("rst_hit_zero", hit_cnt, 32'h0);
    chk("rst_miss_zero", miss_cnt, 32'h0);
    // saturation of the hit counter
    @(negedge clk);
    force dut.u_hit.count = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.u_hit.count;
    #1 chk("sat_preload", hit_cnt, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      v = '{1'b0, 32'h40, {16{8'hA5}}, 1'b1, 32'hFFFF_FFFF, 32'd0, 0, 0};
      issue(v, w);
      wait_done();
    end
    chk("sat_final", hit_cnt, 32'hFFFF_FFFF);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
